// File: rtl/bit_serial_deser.sv
// Collects an LSB-first serial word from a bit-serial adder into a parallel result with a valid/ack handshake.
// Optional final-carry capture is enabled by defining DESER_CARRY_EN; otherwise cout is constant 0.
module bit_serial_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin,
   input  logic             cin_final,
   input  logic             ack,
   output logic [WIDTH-1:0] pout,
   output logic             cout,
   output logic             busy,
   output logic             valid
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [WIDTH-1:0]  pout_q, pout_d;
   logic              last_bit;

   always_comb begin
      // NOTE: every comb output is defaulted first so no path leaves a value unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      pout_d   = pout_q;
      last_bit = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shift_d = {sin, shift_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               last_bit = 1'b1;
               pout_d   = {sin, shift_q[WIDTH-1:1]};
               state_d  = DONE;
            end
         end
         DONE: begin
            // A new start implicitly acknowledges the held word.
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the shift register is small, so it is reset along with the control state rather than left undefined.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         pout_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pout_q  <= pout_d;
      end
   end

`ifdef DESER_CARRY_EN
   logic cout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cout_q <= 1'b0;
      else if (last_bit) cout_q <= cin_final;
   end

   assign cout = cout_q;
`else
   logic unused_carry;

   assign unused_carry = cin_final ^ last_bit;
   assign cout         = 1'b0;
`endif

   assign pout  = pout_q;
   assign busy  = (state_q == SHIFT);
   assign valid = (state_q == DONE);

endmodule
